// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss clock with a run-mode prescaler, an edit mode
// that increments one field at a time without carry, and a blink mask that
// flashes the field being edited.
module time_keeper #(
  parameter int unsigned CLK_DIV   = 26214400,
  parameter int unsigned BLINK_DIV = 13107200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Editing,
  input  logic [2:0] Digit,
  input  logic       IncrementDigit,
  output logic [3:0] HourT,
  output logic [3:0] HourU,
  output logic [3:0] MinT,
  output logic [3:0] MinU,
  output logic [3:0] SecT,
  output logic [3:0] SecU,
  output logic       SecondTick,
  output logic [2:0] Blank
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] pre_reg;
  logic [BW-1:0] bcnt_reg;
  logic          phase_reg;
  logic [7:0]    sec_reg, min_reg, hour_reg;
  logic [7:0]    sec_next, min_next, hour_next;
  logic          tick_reg;
  logic [2:0]    blank_reg;
  logic          tick;
  logic          inc_ok;

  // Increment a two-digit BCD value, wrapping to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // A tick can only happen in run mode, so it never races an edit.
  assign tick   = !Editing && (pre_reg == PRE_LAST);
  assign inc_ok = Editing && IncrementDigit &&
                  ((Digit == 3'b001) || (Digit == 3'b010) || (Digit == 3'b100));

  // Prescaler: free-runs in run mode, parked at 0 while editing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pre_reg <= '0;
    else if (Editing || tick)
      pre_reg <= '0;
    else
      pre_reg <= pre_reg + 1'b1;
  end

  // Next-time logic: cascaded carry on tick, isolated field wrap on edit.
  always_comb begin
    sec_next  = sec_reg;
    min_next  = min_reg;
    hour_next = hour_reg;
    if (tick) begin
      sec_next = bcd_inc(sec_reg, 8'h59);
      if (sec_reg == 8'h59) begin
        min_next = bcd_inc(min_reg, 8'h59);
        if (min_reg == 8'h59)
          hour_next = bcd_inc(hour_reg, 8'h23);
      end
    end else if (inc_ok) begin
      case (Digit)
        3'b001:  sec_next  = bcd_inc(sec_reg, 8'h59);
        3'b010:  min_next  = bcd_inc(min_reg, 8'h59);
        3'b100:  hour_next = bcd_inc(hour_reg, 8'h23);
        default: ;
      endcase
    end
  end

  // Time registers and the registered second pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sec_reg  <= 8'h00;
      min_reg  <= 8'h00;
      hour_reg <= 8'h00;
      tick_reg <= 1'b0;
    end else begin
      sec_reg  <= sec_next;
      min_reg  <= min_next;
      hour_reg <= hour_next;
      tick_reg <= tick;
    end
  end

  // Blink phase: runs only in edit mode; a press restarts it so the field shows.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (!Editing || IncrementDigit) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (bcnt_reg == BLINK_LAST) begin
      bcnt_reg  <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      bcnt_reg <= bcnt_reg + 1'b1;
    end
  end

  // Registered blank mask for the selected field during the off phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      blank_reg <= 3'b000;
    else if (Editing)
      blank_reg <= Digit & {3{phase_reg}};
    else
      blank_reg <= 3'b000;
  end

  assign HourT      = hour_reg[7:4];
  assign HourU      = hour_reg[3:0];
  assign MinT       = min_reg[7:4];
  assign MinU       = min_reg[3:0];
  assign SecT       = sec_reg[7:4];
  assign SecU       = sec_reg[3:0];
  assign SecondTick = tick_reg;
  assign Blank      = blank_reg;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed stimulus pushes hand-computed expectations into a
// scoreboard queue; an independent monitor pops and compares on each falling edge.
module tb_time_keeper;

  logic       CLK;
  logic       RST;
  logic       Editing;
  logic [2:0] Digit;
  logic       IncrementDigit;
  logic [3:0] HourT, HourU, MinT, MinU, SecT, SecU;
  logic       SecondTick;
  logic [2:0] Blank;

  localparam logic [2:0] M_T = 3'b001;  // compare time digits
  localparam logic [2:0] M_K = 3'b010;  // compare SecondTick
  localparam logic [2:0] M_B = 3'b100;  // compare Blank
  localparam logic [2:0] M_A = 3'b111;

  typedef struct {
    string      nm;
    logic [23:0] t;
    logic        tk;
    logic [2:0]  bl;
    logic [2:0]  mask;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  time_keeper #(.CLK_DIV(4), .BLINK_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .Editing(Editing), .Digit(Digit),
    .IncrementDigit(IncrementDigit),
    .HourT(HourT), .HourU(HourU), .MinT(MinT), .MinU(MinU), .SecT(SecT), .SecU(SecU),
    .SecondTick(SecondTick), .Blank(Blank)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_exp(input string nm, input logic [23:0] t, input logic tk,
                          input logic [2:0] bl, input logic [2:0] mask);
    exp_t e;
    e.nm = nm; e.t = t; e.tk = tk; e.bl = bl; e.mask = mask;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic edge_chk(input string nm, input logic [23:0] t, input logic tk,
                          input logic [2:0] bl, input logic [2:0] mask);
    cyc();
    push_exp(nm, t, tk, bl, mask);
  endtask

  // n edit edges with IncrementDigit held; only the last checks the time.
  task automatic pulses(input int n, input string nm, input logic [23:0] fin);
    for (int i = 1; i <= n; i++) begin
      if (i == n) edge_chk(nm, fin, 1'b0, 3'b000, M_T | M_K);
      else        edge_chk("edit_no_tick", 24'h0, 1'b0, 3'b000, M_K);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    logic [23:0] act;
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {HourT, HourU, MinT, MinU, SecT, SecU};
        if (e.mask[0]) begin
          n_checks++;
          if (act !== e.t) begin
            n_fail++;
            $display("FAIL %s time: got %h required %h", e.nm, act, e.t);
          end
        end
        if (e.mask[1]) begin
          n_checks++;
          if (SecondTick !== e.tk) begin
            n_fail++;
            $display("FAIL %s SecondTick: got %b required %b", e.nm, SecondTick, e.tk);
          end
        end
        if (e.mask[2]) begin
          n_checks++;
          if (Blank !== e.bl) begin
            n_fail++;
            $display("FAIL %s Blank: got %b required %b", e.nm, Blank, e.bl);
          end
        end
        $display("t=%0t %s time=%h tick=%b blank=%b", $time, e.nm, act, SecondTick, Blank);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; Editing = 1'b0; Digit = 3'b001; IncrementDigit = 1'b0;

    // Reset state and first second after release.
    for (int i = 0; i < 3; i++) edge_chk("reset_hold", 24'h000000, 1'b0, 3'b000, M_A);
    RST = 1'b0;
    for (int i = 1; i <= 3; i++) edge_chk("run_pre", 24'h000000, 1'b0, 3'b000, M_A);
    edge_chk("first_tick", 24'h000001, 1'b1, 3'b000, M_A);
    edge_chk("tick_single", 24'h000001, 1'b0, 3'b000, M_T | M_K);
    for (int i = 6; i < 240; i++) cyc();
    edge_chk("one_minute", 24'h000100, 1'b1, 3'b000, M_T | M_K);

    // Edit preload to 23:59:59, exercising no-carry wraps.
    Editing = 1'b1; Digit = 3'b100; IncrementDigit = 1'b1;
    pulses(25, "hour_25_pulses", 24'h010100);
    pulses(22, "hour_to_23", 24'h230100);
    Digit = 3'b010;
    pulses(58, "min_to_59", 24'h235900);
    pulses(1, "min_wrap_no_carry", 24'h230000);
    pulses(59, "min_back_59", 24'h235900);
    Digit = 3'b001;
    pulses(59, "sec_to_59", 24'h235959);

    // Leave edit: full rollover exactly CLK_DIV edges later.
    Editing = 1'b0; IncrementDigit = 1'b0;
    for (int i = 1; i <= 3; i++) edge_chk("exit_pre", 24'h235959, 1'b0, 3'b000, M_A);
    edge_chk("day_rollover", 24'h000000, 1'b1, 3'b000, M_A);

    // Enter edit exactly when the prescaler is at its last count; blink on minutes.
    Digit = 3'b010;
    for (int i = 1; i <= 3; i++) edge_chk("run_to_last", 24'h000000, 1'b0, 3'b000, M_A);
    Editing = 1'b1;
    for (int k = 0; k < 20; k++)
      edge_chk("edit_freeze_blink", 24'h000000, 1'b0, (k % 4 >= 2) ? 3'b010 : 3'b000, M_A);
    Editing = 1'b0;
    for (int i = 1; i <= 3; i++) edge_chk("post_edit_pre", 24'h000000, 1'b0, 3'b000, M_A);
    edge_chk("post_edit_tick", 24'h000001, 1'b1, 3'b000, M_A);

    // Illegal selects and run-mode presses are ignored.
    Editing = 1'b1; Digit = 3'b011; IncrementDigit = 1'b1;
    for (int i = 0; i < 2; i++) edge_chk("digit_011_ignored", 24'h000001, 1'b0, 3'b000, M_T | M_K);
    Digit = 3'b000;
    edge_chk("digit_000_ignored", 24'h000001, 1'b0, 3'b000, M_T | M_K);
    Editing = 1'b0; Digit = 3'b001;
    for (int i = 0; i < 3; i++) edge_chk("run_press_ignored", 24'h000001, 1'b0, 3'b000, M_A);

    // Preload 12:34:56 then reset asynchronously while hours blank.
    Editing = 1'b1; Digit = 3'b100;
    pulses(12, "hour_to_12", 24'h120001);
    Digit = 3'b010;
    pulses(34, "min_to_34", 24'h123401);
    Digit = 3'b001;
    pulses(55, "sec_to_56", 24'h123456);
    IncrementDigit = 1'b0; Digit = 3'b100;
    edge_chk("press_shows_field", 24'h123456, 1'b0, 3'b000, M_A);
    edge_chk("press_shows_field", 24'h123456, 1'b0, 3'b000, M_A);
    edge_chk("blank_hours", 24'h123456, 1'b0, 3'b100, M_A);
    cyc();
    RST = 1'b1;
    #1;
    push_exp("async_reset", 24'h000000, 1'b0, 3'b000, M_A);
    edge_chk("reset_hold2", 24'h000000, 1'b0, 3'b000, M_A);
    RST = 1'b0; Editing = 1'b0;
    for (int i = 1; i <= 3; i++) edge_chk("rerun_pre", 24'h000000, 1'b0, 3'b000, M_A);
    edge_chk("rerun_tick", 24'h000001, 1'b1, 3'b000, M_A);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_DIV, default 26214400, CLK cycles per second; legal range 2 or more.
REQ-002 SHALL have parameter BLINK_DIV, default 13107200, CLK cycles per blink half-period; legal range 1 or more.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Editing  input  1  1 = edit mode (time frozen), 0 = run mode; level from upstream mode control.
REQ-006 Digit  input  3  one-hot field select: 001 seconds, 010 minutes, 100 hours.
REQ-007 IncrementDigit  input  1  single-cycle pulse, increment selected field.
REQ-008 HourT, HourU, MinT, MinU, SecT, SecU  output  4 each  registered BCD time digits.
REQ-009 SecondTick  output  1  registered one-cycle pulse on each run-mode second advance.
REQ-010 Blank  output  3  per-field display blank mask, bit order as Digit.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 in run mode; tick SHALL occur in the cycle it equals CLK_DIV-1, and it SHALL then wrap to 0.
REQ-012 While Editing=1, prescaler SHALL be held at 0 and no tick SHALL occur, including when Editing rises in the cycle the prescaler equals CLK_DIV-1.
REQ-013 After Editing falls, the first tick SHALL occur exactly CLK_DIV cycles later.
REQ-014 On tick: seconds +1; 59->00 SHALL carry to minutes; minutes 59->00 SHALL carry to hours; hours 23->00 with no further carry; all cascaded updates in the same cycle.
REQ-015 SecondTick SHALL be 1 for exactly the cycle after the tick, coincident with the updated digits.
REQ-016 Edit mode: IncrementDigit=1 with Digit exactly one-hot SHALL increment only the selected field by 1, visible one cycle later.
REQ-017 Edit increments SHALL wrap without carry: seconds 59->00, minutes 59->00, hours 23->00.
REQ-018 IncrementDigit SHALL be ignored when Editing=0, or when Digit is 000 or has more than one bit set.
REQ-019 Digits SHALL always hold valid BCD: tens 0-5 for minutes/seconds, 0-2 for hours; hours never above 23.
REQ-020 Blink phase counter SHALL count 0..BLINK_DIV-1 while Editing=1, toggling a phase bit at each wrap; counter and phase SHALL be cleared while Editing=0.
REQ-021 Blank SHALL equal Digit AND phase while Editing=1, and 000 while Editing=0; it is registered.
REQ-022 IncrementDigit SHALL clear blink counter and phase so the edited field is visible immediately after a press.
REQ-023 A Digit change mid-edit SHALL NOT reset the blink phase.

Reset
REQ-024 RST=1 SHALL immediately force all digits to 0 (00:00:00), prescaler 0, blink counter and phase 0, SecondTick 0, Blank 000.
REQ-025 After RST deasserts, with Editing=0, the first tick SHALL occur CLK_DIV cycles after the first active clock edge.
REQ-026 RST asserted mid-edit or mid-carry SHALL abandon the operation with no partial update surviving.

Verification (CLK_DIV=4, BLINK_DIV=2)
REQ-027 Reset, Editing=0, run 4 cycles -> SecU=1, SecondTick single pulse; after 240 cycles -> 00:01:00.
REQ-028 Preload 23:59:59 via edit, exit edit, 4 cycles -> 00:00:00 on one edge, SecondTick=1.
REQ-029 Editing=1, Digit=100, 25 IncrementDigit pulses from 00 -> hours=01; Digit=010 from 59 -> minutes=00 with hours unchanged.
REQ-030 Editing=1 for 20 cycles -> time unchanged, SecondTick never 1; fall of Editing -> next tick exactly 4 cycles later.
REQ-031 Editing=1, Digit=010 -> Blank toggles 000/010 every 2 cycles; Digit=011 or IncrementDigit with Editing=0 -> time unchanged.
REQ-032 Assert RST mid-edit at 12:34:56 with Blank=100 -> all digits 0 and Blank=000 before the next CLK edge.
